// File: rtl/dynamic_segment_decoder_if.sv
// Pin-level bundle between a multiplexed 7-segment display bus and its decoder.
// The display side drives com/data; the decoder returns the captured frame.
interface dynamic_segment_decoder_if;
   logic [3:0]  com;
   logic [7:0]  data;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        frame_valid;
   logic        seg_err;
   logic        com_err;

   modport master (
      output com, data,
      input  digits, dp, blank, frame_valid, seg_err, com_err
   );

   modport slave (
      input  com, data,
      output digits, dp, blank, frame_valid, seg_err, com_err
   );
endinterface

// File: rtl/dynamic_segment_decoder.sv
// Snoops a multiplexed 4-digit 7-segment bus, debounces each digit dwell,
// decodes the segment pattern to a hex code and publishes whole frames only.
module dynamic_segment_decoder #(
   parameter int unsigned STABLE_CYC = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   dynamic_segment_decoder_if.slave    bus
);

   localparam logic [7:0] LOAD = 8'(STABLE_CYC - 1);

   logic [11:0] in_q, in_d;
   logic        active_q, active_d;
   logic [7:0]  remain_q, remain_d;
   logic        new_dwell, accept;

   logic [3:0]  seen_q, seen_d;
   logic [15:0] shadow_code_q, shadow_code_d;
   logic [3:0]  shadow_dp_q, shadow_dp_d;
   logic [3:0]  shadow_blank_q, shadow_blank_d;

   logic [15:0] digits_q, digits_d;
   logic [3:0]  dp_q, dp_d;
   logic [3:0]  blank_q, blank_d;
   logic        frame_valid_q, frame_valid_d;
   logic        seg_err_q, seg_err_d;
   logic        com_err_q, com_err_d;

   logic [2:0]  n_low;
   logic [1:0]  slot;
   logic [5:0]  dec;

   // {ok, blank, code}; dp is not part of the segment pattern.
   function automatic logic [5:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'b1111110: seg_decode = {2'b10, 4'h0};
         7'b0110000: seg_decode = {2'b10, 4'h1};
         7'b1101101: seg_decode = {2'b10, 4'h2};
         7'b1111001: seg_decode = {2'b10, 4'h3};
         7'b0110011: seg_decode = {2'b10, 4'h4};
         7'b1011011: seg_decode = {2'b10, 4'h5};
         7'b1011111: seg_decode = {2'b10, 4'h6};
         7'b1110000: seg_decode = {2'b10, 4'h7};
         7'b1111111: seg_decode = {2'b10, 4'h8};
         7'b1111011: seg_decode = {2'b10, 4'h9};
         7'b1110111: seg_decode = {2'b10, 4'hA};
         7'b0011111: seg_decode = {2'b10, 4'hB};
         7'b1001110: seg_decode = {2'b10, 4'hC};
         7'b0111101: seg_decode = {2'b10, 4'hD};
         7'b1001111: seg_decode = {2'b10, 4'hE};
         7'b1000111: seg_decode = {2'b10, 4'hF};
         7'b0000000: seg_decode = {2'b11, 4'h0};
         default:    seg_decode = {2'b00, 4'h0};
      endcase
   endfunction

   // Dwell tracking: a down-counter loaded on every change of the sample,
   // accepting on terminal count and parking at zero so a long dwell fires once.
   // The sample being registered this edge is what gets judged, so with
   // STABLE_CYC=1 a dwell is accepted on its very first edge.
   always_comb begin
      in_d      = {bus.com, bus.data};
      active_d  = 1'b1;
      new_dwell = !active_q || (in_d != in_q);
      remain_d  = remain_q;
      accept    = 1'b0;
      if (new_dwell) begin
         remain_d = LOAD;
         accept   = (LOAD == 8'd0);
      end else if (remain_q != 8'd0) begin
         remain_d = remain_q - 8'd1;
         accept   = (remain_q == 8'd1);
      end
   end

   // Classify the digit select: count low com bits and remember which one.
   always_comb begin
      n_low = 3'd0;
      slot  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!in_d[8+i]) begin
            n_low = n_low + 3'd1;
            slot  = 2'(i);
         end
      end
      dec = seg_decode(in_d[7:1]);
   end

   // Shadow/frame update for an accepted dwell; only one pulse type can fire.
   always_comb begin
      seen_d         = seen_q;
      shadow_code_d  = shadow_code_q;
      shadow_dp_d    = shadow_dp_q;
      shadow_blank_d = shadow_blank_q;
      digits_d       = digits_q;
      dp_d           = dp_q;
      blank_d        = blank_q;
      frame_valid_d  = 1'b0;
      seg_err_d      = 1'b0;
      com_err_d      = 1'b0;
      if (accept) begin
         if (n_low >= 3'd2) begin
            com_err_d = 1'b1;
         end else if (n_low == 3'd1) begin
            if (!dec[5]) begin
               seg_err_d = 1'b1;
            end else begin
               shadow_code_d[{slot, 2'b00} +: 4] = dec[3:0];
               shadow_dp_d[slot]    = in_d[0];
               shadow_blank_d[slot] = dec[4];
               seen_d[slot]         = 1'b1;
               if (&seen_d) begin
                  digits_d      = shadow_code_d;
                  dp_d          = shadow_dp_d;
                  blank_d       = shadow_blank_d;
                  frame_valid_d = 1'b1;
                  seen_d        = 4'b0000;
               end
            end
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_q           <= {4'b1111, 8'h00};
         active_q       <= 1'b0;
         remain_q       <= 8'd0;
         seen_q         <= 4'b0000;
         shadow_code_q  <= 16'h0000;
         shadow_dp_q    <= 4'b0000;
         shadow_blank_q <= 4'b0000;
         digits_q       <= 16'h0000;
         dp_q           <= 4'b0000;
         blank_q        <= 4'b1111;
         frame_valid_q  <= 1'b0;
         seg_err_q      <= 1'b0;
         com_err_q      <= 1'b0;
      end else begin
         in_q           <= in_d;
         active_q       <= active_d;
         remain_q       <= remain_d;
         seen_q         <= seen_d;
         shadow_code_q  <= shadow_code_d;
         shadow_dp_q    <= shadow_dp_d;
         shadow_blank_q <= shadow_blank_d;
         digits_q       <= digits_d;
         dp_q           <= dp_d;
         blank_q        <= blank_d;
         frame_valid_q  <= frame_valid_d;
         seg_err_q      <= seg_err_d;
         com_err_q      <= com_err_d;
      end
   end

   assign bus.digits      = digits_q;
   assign bus.dp          = dp_q;
   assign bus.blank       = blank_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.seg_err     = seg_err_q;
   assign bus.com_err     = com_err_q;

endmodule
